// File: rtl/tile_fp_div_iter.sv
// Iterative FP divider: pair-joined operand streams, restoring radix-2 mantissa loop, IEEE status flags.
// Optional FP_DIV_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the quotient truncates.
module tile_fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 2**(EXP_W-1)-1,
  localparam int W    = 1+EXP_W+MAN_W
) (
  input  logic         clk_line,
  input  logic         clk_line_rst_high,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  input  logic         a_last,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  output logic         b_ready,
  output logic         q_valid,
  output logic [W-1:0] q_data,
  output logic         q_last,
  output logic [3:0]   q_status,
  input  logic         q_ready,
  output logic         busy
);
  localparam int QW = MAN_W+2;
  localparam int CW = $clog2(QW+1);
  localparam int XW = EXP_W+2;
  localparam logic signed [XW-1:0] E_MAX = XW'(2**EXP_W-1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} state_t;
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp_t;

  state_t state, state_nx;
  fp_t    fa, fb;
  logic   fire, sign_in;
  logic   a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  logic             sp_hit;
  logic [W-1:0]     sp_data;
  logic [3:0]       sp_st;

  logic             sign_r, last_r;
  logic [EXP_W-1:0] ea_r, eb_r;
  logic [MAN_W:0]   mb_r;
  logic [QW-1:0]    rem, quo, diff;
  logic [CW-1:0]    cnt;
  logic             ge;

  logic signed [XW-1:0] e, e_r;
  logic [MAN_W-1:0]     frac, frac_r;
  logic [W-1:0]         n_data;
  logic [3:0]           n_st;

  assign fa      = a_data;
  assign fb      = b_data;
  assign sign_in = fa.sign ^ fb.sign;
  // subnormals are flushed: a zero exponent means zero regardless of fraction
  assign a_zero  = (fa.exp == '0);
  assign a_inf   = (&fa.exp) && (fa.frac == '0);
  assign a_nan   = (&fa.exp) && (fa.frac != '0);
  assign b_zero  = (fb.exp == '0);
  assign b_inf   = (&fb.exp) && (fb.frac == '0);
  assign b_nan   = (&fb.exp) && (fb.frac != '0);
  assign fire    = (state == IDLE) && a_valid && b_valid;

  always_comb begin
    sp_hit  = 1'b1;
    sp_data = '0;
    sp_st   = '0;
    if (a_nan || b_nan) begin
      sp_data = QNAN;  sp_st = 4'b1000;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_data = QNAN;  sp_st = 4'b1000;
    end else if (a_inf) begin
      sp_data = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      sp_data = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};  sp_st = 4'b0100;
    end else if (a_zero || b_inf) begin
      sp_data = {sign_in, {(W-1){1'b0}}};
    end else begin
      sp_hit = 1'b0;
    end
  end

  // one restoring step; in NORM the same compare yields the bit after the quotient LSB
  assign ge   = (rem >= {1'b0, mb_r});
  assign diff = rem - (ge ? {1'b0, mb_r} : '0);

  always_comb begin
    frac = quo[QW-1] ? quo[QW-2:1] : quo[QW-3:0];
    e    = XW'(ea_r) - XW'(eb_r) + XW'(BIAS) - (quo[QW-1] ? XW'(0) : XW'(1));
`ifdef FP_DIV_ROUND_NEAREST_EN
    begin
      logic g, s, inc, carry;
      g   = quo[QW-1] ? quo[0] : ge;
      s   = quo[QW-1] ? |rem : |diff;
      inc = g & (s | frac[0]);
      {carry, frac_r} = {1'b0, frac} + (MAN_W+1)'(inc);
      e_r = e + XW'(carry);
    end
`else
    frac_r = frac;
    e_r    = e;
`endif
    n_st = '0;
    if (e_r >= E_MAX) begin
      n_data = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};  n_st = 4'b0010;
    end else if (e_r[XW-1] || (e_r == '0)) begin
      n_data = {sign_r, {(W-1){1'b0}}};  n_st = 4'b0001;
    end else begin
      n_data = {sign_r, e_r[EXP_W-1:0], frac_r};
    end
  end

  always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
    if (clk_line_rst_high) state <= IDLE;
    else                   state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fire) state_nx = sp_hit ? DONE : ITER;
      ITER:    if (cnt == CW'(QW-1)) state_nx = NORM;
      NORM:    state_nx = DONE;
      DONE:    if (q_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    a_ready = fire;
    b_ready = fire;
    q_valid = (state == DONE);
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk_line or posedge clk_line_rst_high) begin
    if (clk_line_rst_high) begin
      sign_r <= 1'b0;  last_r <= 1'b0;
      ea_r <= '0;  eb_r <= '0;  mb_r <= '0;
      rem <= '0;  quo <= '0;  cnt <= '0;
      q_data <= '0;  q_last <= 1'b0;  q_status <= '0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          sign_r <= sign_in;
          last_r <= a_last;
          ea_r   <= fa.exp;
          eb_r   <= fb.exp;
          mb_r   <= {1'b1, fb.frac};
          rem    <= {1'b0, 1'b1, fa.frac};
          quo    <= '0;
          cnt    <= '0;
          if (sp_hit) begin
            q_data <= sp_data;  q_status <= sp_st;  q_last <= a_last;
          end
        end
        ITER: begin
          quo <= {quo[QW-2:0], ge};
          rem <= diff << 1;
          cnt <= cnt + 1'b1;
        end
        NORM: begin
          q_data <= n_data;  q_status <= n_st;  q_last <= last_r;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tile_fp_div_iter.sv
// Directed bench for tile_fp_div_iter (FP32): scoreboard queue of expected results, popped on output handshake.
module tb_tile_fp_div_iter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        a_valid = 0, a_last = 0, b_valid = 0, q_ready = 1;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, q_valid, q_last, busy;
  logic [31:0] q_data;
  logic [3:0]  q_status;

  typedef struct { logic [31:0] data; logic [3:0] st; logic last; } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  tile_fp_div_iter dut (
    .clk_line(clk), .clk_line_rst_high(rst),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .q_valid(q_valid), .q_data(q_data), .q_last(q_last), .q_status(q_status),
    .q_ready(q_ready), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q_valid === 1'b1 && q_ready) begin
      exp_t x;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk("q_data", q_data, x.data);
        chk("q_status", 32'(q_status), 32'(x.st));
        chk("q_last", 32'(q_last), 32'(x.last));
      end
    end
  end

  // present a pair, wait for the join, then measure cycles until q_valid
  task automatic send(input string tag, input logic [31:0] a, b, input logic last,
                      input logic [31:0] ed, input logic [3:0] es, input int elat,
                      output int waited);
    int lat;
    a_valid = 1; b_valid = 1; a_data = a; b_data = b; a_last = last;
    #1;
    waited = 0;
    while (!a_ready && waited < 100) begin @(posedge clk); #1; waited++; end
    chk({tag, "_join"}, 32'(a_ready & b_ready), 32'd1);
    sb.push_back('{ed, es, last});
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0; a_last = 0;
    lat = 1;
    while (!q_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
  endtask

  task automatic op(input string tag, input logic [31:0] a, b, input logic last,
                    input logic [31:0] ed, input logic [3:0] es, input int elat);
    int w;
    send(tag, a, b, last, ed, es, elat, w);
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    logic [31:0] third;
`ifdef FP_DIV_ROUND_NEAREST_EN
    third = 32'h3EAAAAAB;
`else
    third = 32'h3EAAAAAA;
`endif
    #1;
    chk("rst_q_valid", 32'(q_valid), 0);
    chk("rst_q_data", q_data, 0);
    chk("rst_q_last", 32'(q_last), 0);
    chk("rst_q_status", 32'(q_status), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    op("six_two", 32'h40C00000, 32'h40000000, 1, 32'h40400000, 4'b0000, 27);
    op("one_third", 32'h3F800000, 32'h40400000, 0, third, 4'b0000, 27);
    op("neg", 32'hC0C00000, 32'h40000000, 0, 32'hC0400000, 4'b0000, 27);
    op("div_zero", 32'h3F800000, 32'h00000000, 0, 32'h7F800000, 4'b0100, 1);
    op("zero_zero", 32'h00000000, 32'h00000000, 1, 32'h7FC00000, 4'b1000, 1);
    op("subnorm", 32'h00000001, 32'h3F800000, 0, 32'h00000000, 4'b0000, 1);
    op("nan", 32'hFFC00001, 32'h3F800000, 0, 32'h7FC00000, 4'b1000, 1);
    op("inf_x", 32'hFF800000, 32'h40000000, 0, 32'hFF800000, 4'b0000, 1);
    op("x_inf", 32'hBF800000, 32'h7F800000, 0, 32'h80000000, 4'b0000, 1);
    op("ovf", 32'h7F000000, 32'h3E800000, 0, 32'h7F800000, 4'b0010, 27);
    op("unf", 32'h00800000, 32'h40000000, 0, 32'h00000000, 4'b0001, 27);

    // backpressure: result held, next pair waits until one cycle after the output handshake
    q_ready = 0;
    send("bp", 32'h40C00000, 32'h40000000, 1, 32'h40400000, 4'b0000, 27, w);
    a_valid = 1; b_valid = 1; a_data = 32'h41000000; b_data = 32'h40000000;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", q_data, 32'h40400000);
      chk("bp_ready", 32'(a_ready | b_ready), 0);
      @(posedge clk); #1;
    end
    chk("bp_valid", 32'(q_valid), 1);
    q_ready = 1;
    #1 chk("bp_ready_hs", 32'(a_ready), 0);
    @(posedge clk); #1;
    send("bp_next", 32'h41000000, 32'h40000000, 0, 32'h40800000, 4'b0000, 27, w);
    chk("bp_next_wait", 32'(w), 0);
    @(posedge clk); #1;

    // stream join: dividend alone is never consumed
    a_valid = 1; b_valid = 0; a_data = 32'h40C00000; b_data = 32'h40000000;
    for (int i = 0; i < 5; i++) begin
      #1 chk("join_solo", 32'(a_ready | b_ready | busy), 0);
      @(posedge clk); #1;
    end
    b_valid = 1;
    #1 chk("join_pair", 32'(a_ready), 1);
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
    repeat (10) begin @(posedge clk); #1; end
    chk("iter_busy", 32'(busy), 1);
    #2 rst = 1;
    #1;
    chk("rst_mid_valid", 32'(q_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_data", q_data, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    op("after_rst", 32'h40C00000, 32'h40000000, 1, 32'h40400000, 4'b0000, 27);

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tile_fp_div_iter.md
Name: tile_fp_div_iter

Overview:
Parametrised iterative floating-point divider core for the FP tile family, intended as the next-generation DIV datapath behind the tile's stream interface. Generic format: EXP_W exponent bits and MAN_W fraction bits.
- Joins a dividend stream and a divisor stream into one operation.
- Computes the quotient with a restoring radix-2 mantissa loop.
- Emits the result plus IEEE status flags on a valid/ready output stream, with TLAST carried through.
- One operation in flight.

Parameters:
EXP_W, 8, exponent width
MAN_W, 23, stored fraction width; word width W = 1+EXP_W+MAN_W
BIAS, 2**(EXP_W-1)-1, exponent bias

Ports:
clk_line  in  1  line clock
clk_line_rst_high  in  1  asynchronous active-high reset
a_valid  in  1  dividend valid
a_data  in  W  dividend
a_last  in  1  TLAST of dividend stream, forwarded
a_ready  out  1  dividend accepted
b_valid  in  1  divisor valid
b_data  in  W  divisor
b_ready  out  1  divisor accepted
q_valid  out  1  result valid
q_data  out  W  quotient
q_last  out  1  forwarded a_last
q_status  out  4  {invalid, div_by_zero, overflow, underflow}
q_ready  in  1  result consumer ready
busy  out  1  state != IDLE

Behaviour:
Interface:
- Single clock clk_line.
- Reset clk_line_rst_high is asynchronous, active-high.
- Reset values: state IDLE; q_valid, q_data, q_last, q_status, busy all 0.

States: IDLE, ITER, NORM, DONE.

IDLE:
- a_ready = b_ready = (a_valid & b_valid). Operands are consumed only as a pair, so neither stream is ever consumed alone.
- On the pair handshake, the core registers the operands and a_last.
- Special cases go straight to DONE. Anything else goes to ITER.

Special-case results, in priority order (subnormal inputs flushed to signed zero first):
- NaN operand -> 0x7FC..0 canonical qNaN, invalid.
- 0/0 or Inf/Inf -> qNaN, invalid.
- Inf/x -> signed Inf, no flag.
- x/0 -> signed Inf, div_by_zero.
- 0/x or x/Inf -> signed zero, no flag.
- Sign is always sa^sb, except for NaN (sign 0).

ITER:
- Dividend and divisor mantissas include the hidden 1.
- MAN_W+2 cycles, one quotient bit per cycle, via a cycle counter.
- Remainder width is MAN_W+2.
- Sticky = |remainder at the end.

NORM (1 cycle):
- If quotient MSB = 0: shift left 1, and biased exponent e = ea - eb + BIAS - 1. Otherwise e = ea - eb + BIAS.
- Exponent arithmetic is computed in EXP_W+2 signed bits.
- Rounding: truncation; RNE under the optional feature below.
- If e >= 2**EXP_W-1 (including after rounding carry) -> signed Inf, overflow.
- If e <= 0 -> signed zero, underflow (no subnormal outputs).

DONE:
- q_valid = 1; q_data, q_last and q_status are held stable until q_ready.
- On q_valid & q_ready -> IDLE.
- No new operands are accepted in the same cycle; the next pair is accepted at the earliest one cycle after the output handshake.

Latency, with the operand handshake in cycle N:
- Special case: q_valid at N+1.
- Normal: q_valid at N+MAN_W+4 (27 cycles for FP32).

Boundary rules:
- q_ready held low: the core stays in DONE indefinitely, with a_ready and b_ready low.
- Reset asserted mid-ITER or mid-DONE: the operation is discarded, all outputs return to reset values immediately, and the core restarts in IDLE.
- Only one of a_valid/b_valid high: no handshake, state unchanged.

Optional Feature:
FP_DIV_ROUND_NEAREST_EN
- Defined: round-to-nearest-even using guard bit G (quotient LSB+1) and sticky S.
  - Increment when G & (S | LSB).
  - A mantissa carry-out increments the exponent and re-checks overflow.
  - Normal latency is unchanged, because rounding is done inside NORM.
- Undefined: truncation toward zero. G and S are discarded; overflow can only come from the exponent.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0), a_last=1 -> q_data 0x40400000, q_last=1, q_status 0, q_valid exactly 27 cycles after the handshake.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA without the macro, 0x3EAAAAAB with FP_DIV_ROUND_NEAREST_EN; status 0.
- Special cases: each gives q_valid at N+1.
  - 0x3F800000 / 0x00000000 -> 0x7F800000, status 4'b0100.
  - 0x00000000 / 0x00000000 -> 0x7FC00000, status 4'b1000.
  - 0x00000001 (subnormal) / 0x3F800000 -> 0x00000000.
- Range limits:
  - 0x7F000000 / 0x3E800000 -> 0x7F800000, status 4'b0010.
  - 0x00800000 / 0x40000000 -> 0x00000000, status 4'b0001.
- Backpressure: hold q_ready=0 for 10 cycles after q_valid; present the next operand pair meanwhile -> q_data held stable, a_ready=b_ready=0 throughout; the pair is accepted one cycle after the output handshake.
- Stream join and reset: a_valid=1 with b_valid=0 for 5 cycles -> no accept. Then assert reset at ITER cycle 10 -> q_valid=0 and busy=0 asynchronously; the next pair after reset completes correctly.
